// File: rtl/note_dds_pkg.sv
// rtl/note_dds_pkg.sv - shared types, constants and top-octave increment table for note_to_adder
package note_dds_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        LOOKUP,
        SHIFT
    } state_t;

    localparam int NOTE_MAX   = 127;
    localparam int SEMIS      = 12;
    localparam int TOP_OCT    = 10;
    localparam int TAB_CLK_HZ = 10_000_000;

    // round(f(note 120+s) * 2^32 / 10 MHz), notes 120..131
    localparam logic [31:0] TAB [SEMIS] = '{
        32'd3595754, 32'd3809569, 32'd4036098, 32'd4276097,
        32'd4530367, 32'd4799756, 32'd5085165, 32'd5387544,
        32'd5707904, 32'd6047314, 32'd6406906, 32'd6787880
    };

    // Rescales a 10 MHz table entry to another clock; identity at 10 MHz.
    function automatic logic [31:0] scale_tab(input logic [31:0] base, input longint clk_hz);
        longint p;
        p = (longint'(base) * longint'(TAB_CLK_HZ) + clk_hz / 2) / clk_hz;
        return p[31:0];
    endfunction

endpackage

// File: rtl/note_div12.sv
// rtl/note_div12.sv - sequential subtract-by-12 splitting a note into octave and semitone
module note_div12
    import note_dds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] note,
    output logic [3:0] rem,
    output logic [3:0] oct,
    output logic       done
);

    logic [6:0] rem_q;
    logic [3:0] oct_q;
    logic       active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            oct_q  <= '0;
            active <= 1'b0;
        end else if (start) begin
            rem_q  <= note;
            oct_q  <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (rem_q >= 7'(SEMIS)) begin
                rem_q <= rem_q - 7'(SEMIS);
                oct_q <= oct_q + 4'd1;
            end else begin
                active <= 1'b0;
            end
        end
    end

    // done in the same cycle the remainder first drops below 12
    assign done = active && (rem_q < 7'(SEMIS));
    assign rem  = rem_q[3:0];
    assign oct  = oct_q;

endmodule

// File: rtl/note_to_adder.sv
// rtl/note_to_adder.sv - MIDI note to DDS phase increment: divide by 12, table lookup, octave shift
module note_to_adder #(
    parameter int CLK_HZ  = 10_000_000,
    parameter int TOP_OCT = 10,
    parameter int AW      = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [7:0]    NOTE,
    input  logic          NOTE_VALID,
    output logic [AW-1:0] ADDER,
    output logic          ADDER_VALID,
    output logic          BUSY
);

    import note_dds_pkg::*;

    state_t        state;
    state_t        state_nxt;
    logic          div_start;
    logic          div_done;
    logic [3:0]    div_rem;
    logic [3:0]    div_oct;
    logic [6:0]    note_c;
    logic [3:0]    shamt;
    logic [AW-1:0] tabval;
    logic [AW-1:0] tab_rom [SEMIS];

    for (genvar s = 0; s < SEMIS; s++) begin : g_tab
        assign tab_rom[s] = AW'(scale_tab(TAB[s], longint'(CLK_HZ)));
    end

    assign note_c = (NOTE > 8'(NOTE_MAX)) ? 7'(NOTE_MAX) : NOTE[6:0];
    assign shamt  = 4'(TOP_OCT) - div_oct;

    note_div12 u_div (
        .clk   (CLK),
        .rst_n (RESET),
        .start (div_start),
        .note  (note_c),
        .rem   (div_rem),
        .oct   (div_oct),
        .done  (div_done)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (NOTE_VALID) begin
                    div_start = 1'b1;
                    state_nxt = DIV;
                end
            end
            DIV:     if (div_done) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = SHIFT;
            SHIFT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ADDER is only ever written on the SHIFT edge so DDS never sees partial results
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ADDER       <= '0;
            ADDER_VALID <= 1'b0;
            BUSY        <= 1'b0;
            tabval      <= '0;
        end else begin
            ADDER_VALID <= 1'b0;
            if (div_start) begin
                BUSY <= 1'b1;
            end
            if (state == LOOKUP) begin
                tabval <= tab_rom[div_rem];
            end
            if (state == SHIFT) begin
                ADDER       <= tabval >> shamt;
                ADDER_VALID <= 1'b1;
                BUSY        <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_note_to_adder.sv
// tb/tb_note_to_adder.sv - self-checking bench for note_to_adder against a frequency-formula model
module tb_note_to_adder;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  NOTE = 8'd0;
    logic        NOTE_VALID = 1'b0;
    logic [31:0] ADDER;
    logic        ADDER_VALID;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    note_to_adder #(
        .CLK_HZ  (10_000_000),
        .TOP_OCT (10),
        .AW      (32)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .NOTE        (NOTE),
        .NOTE_VALID  (NOTE_VALID),
        .ADDER       (ADDER),
        .ADDER_VALID (ADDER_VALID),
        .BUSY        (BUSY)
    );

    function automatic int ref_tab(input int s);
        real f;
        f = 440.0 * (2.0 ** (real'(51 + s) / 12.0)) * 4294967296.0 / 10000000.0;
        return $rtoi(f + 0.5);
    endfunction

    function automatic logic [31:0] ref_adder(input int note);
        int n;
        n = (note > 127) ? 127 : note;
        return 32'(ref_tab(n % 12)) >> (10 - n / 12);
    endfunction

    function automatic int ref_lat(input int note);
        int n;
        n = (note > 127) ? 127 : note;
        return n / 12 + 3;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Strobes one note and waits for ADDER_VALID; returns in the valid cycle.
    task automatic run_note(input int n, output int lat, output int busy_err);
        NOTE       = 8'(n);
        NOTE_VALID = 1'b1;
        tick();
        NOTE_VALID = 1'b0;
        lat        = -1;
        busy_err   = (BUSY !== 1'b1) ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (ADDER_VALID === 1'b1) begin
                lat = k;
                if (BUSY !== 1'b0) busy_err++;
                break;
            end else if (BUSY !== 1'b1) begin
                busy_err++;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        NOTE  = 8'd69;
        for (int i = 0; i < 5; i++) begin
            NOTE_VALID = i[0];
            tick();
            checks++;
            if ({ADDER, ADDER_VALID, BUSY} !== 34'd0) begin
                errors++;
                $display("FAIL reset_hold: got ADDER=%0d AV=%0b BUSY=%0b expected all zero", ADDER, ADDER_VALID, BUSY);
            end
        end
        NOTE_VALID = 1'b0;
        RESET      = 1'b1;
        tick();
    endtask

    task automatic test_a4();
        int lat, be;
        logic [31:0] exp_v;
        exp_v = ref_adder(69);
        run_note(69, lat, be);
        checks++;
        if (lat !== 8) begin errors++; $display("FAIL a4_latency: got %0d expected 8", lat); end
        checks++;
        if (ADDER !== exp_v) begin errors++; $display("FAIL a4_adder: got %0d expected %0d", ADDER, exp_v); end
        checks++;
        if (be !== 0) begin errors++; $display("FAIL a4_busy: got %0d busy errors expected 0", be); end
        tick();
        checks++;
        if (ADDER_VALID !== 1'b0 || ADDER !== exp_v) begin
            errors++;
            $display("FAIL a4_hold: got AV=%0b ADDER=%0d expected AV=0 ADDER=%0d", ADDER_VALID, ADDER, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        int notes [3] = '{57, 81, 117};
        int lat, be;
        for (int i = 0; i < 3; i++) begin
            run_note(notes[i], lat, be);
            checks++;
            if (ADDER !== ref_adder(notes[i]) || lat !== ref_lat(notes[i])) begin
                errors++;
                $display("FAIL b2b_note%0d: got ADDER=%0d lat=%0d expected ADDER=%0d lat=%0d",
                         notes[i], ADDER, lat, ref_adder(notes[i]), ref_lat(notes[i]));
            end
        end
        tick();
        checks++;
        if (ADDER_VALID !== 1'b0) begin errors++; $display("FAIL b2b_pulse: got AV=%0b expected 0", ADDER_VALID); end
    endtask

    task automatic test_busy_drop();
        int pulses;
        logic [31:0] got;
        NOTE       = 8'd69;
        NOTE_VALID = 1'b1;
        tick();
        NOTE_VALID = 1'b0;
        tick();
        tick();
        checks++;
        if (BUSY !== 1'b1) begin errors++; $display("FAIL drop_busy: got %0b expected 1", BUSY); end
        NOTE       = 8'd81;
        NOTE_VALID = 1'b1;
        tick();
        NOTE_VALID = 1'b0;
        pulses = 0;
        got    = '0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (ADDER_VALID === 1'b1) begin
                pulses++;
                got = ADDER;
            end
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL drop_pulses: got %0d expected 1", pulses); end
        checks++;
        if (got !== ref_adder(69)) begin errors++; $display("FAIL drop_adder: got %0d expected %0d", got, ref_adder(69)); end
    endtask

    task automatic test_clamp_edge();
        int lat, be;
        run_note(200, lat, be);
        checks++;
        if (ADDER !== 32'(ref_tab(7)) || lat !== 13) begin
            errors++;
            $display("FAIL clamp_200: got ADDER=%0d lat=%0d expected ADDER=%0d lat=13", ADDER, lat, ref_tab(7));
        end
        run_note(0, lat, be);
        checks++;
        if (ADDER !== ref_adder(0) || lat !== 3) begin
            errors++;
            $display("FAIL note_0: got ADDER=%0d lat=%0d expected ADDER=%0d lat=3", ADDER, lat, ref_adder(0));
        end
        checks++;
        if (be !== 0) begin errors++; $display("FAIL note_0_busy: got %0d busy errors expected 0", be); end
    endtask

    task automatic test_reset_mid();
        int pulses, lat, be;
        tick();
        NOTE       = 8'd127;
        NOTE_VALID = 1'b1;
        tick();
        NOTE_VALID = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        RESET = 1'b0;
        #1;
        checks++;
        if (ADDER !== 32'd0 || BUSY !== 1'b0 || ADDER_VALID !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got ADDER=%0d BUSY=%0b AV=%0b expected all zero", ADDER, BUSY, ADDER_VALID);
        end
        tick();
        tick();
        RESET  = 1'b1;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (ADDER_VALID === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL midreset_nopulse: got %0d pulses expected 0", pulses); end
        run_note(69, lat, be);
        checks++;
        if (ADDER !== ref_adder(69) || lat !== 8) begin
            errors++;
            $display("FAIL midreset_resume: got ADDER=%0d lat=%0d expected ADDER=%0d lat=8", ADDER, lat, ref_adder(69));
        end
    endtask

    task automatic test_random();
        int n, gap, lat, be;
        for (int i = 0; i < 24; i++) begin
            n   = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            run_note(n, lat, be);
            checks++;
            if (ADDER !== ref_adder(n) || lat !== ref_lat(n) || be !== 0) begin
                errors++;
                $display("FAIL rand_note%0d: got ADDER=%0d lat=%0d busy_err=%0d expected ADDER=%0d lat=%0d busy_err=0",
                         n, ADDER, lat, be, ref_adder(n), ref_lat(n));
            end
        end
    endtask

    initial begin
        test_reset();
        test_a4();
        test_back_to_back();
        test_busy_drop();
        test_clamp_edge();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
